tiled_matmul_engine: RTL and testbench

TILED_MATMUL_ENGINE -- requirements
Module: tiled_matmul_engine

---
 rtl/tiled_matmul_engine_if.sv | 32 +++
 rtl/tiled_matmul_engine.sv | 90 +++++++++
 tb/tb_tiled_matmul_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tiled_matmul_engine_if.sv
// tiled_matmul_engine_if: job control, A/B operand beats and result-row handshakes for the matmul engine
interface tiled_matmul_engine_if #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int KW = 8
);
  localparam int IW = M > 1 ? $clog2(M) : 1;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            a_valid;
  logic            a_ready;
  logic [M*DW-1:0] a_col;
  logic            b_valid;
  logic            b_ready;
  logic [N*DW-1:0] b_row;
  logic            c_valid;
  logic            c_ready;
  logic [N*AW-1:0] c_row;
  logic [IW-1:0]   c_idx;
  logic            busy;
  logic            done;
  modport master (
    output start, k_len, a_valid, a_col, b_valid, b_row, c_ready,
    input  a_ready, b_ready, c_valid, c_row, c_idx, busy, done
  );
  modport slave (
    input  start, k_len, a_valid, a_col, b_valid, b_row, c_ready,
    output a_ready, b_ready, c_valid, c_row, c_idx, busy, done
  );
endinterface

// File: rtl/tiled_matmul_engine.sv
// tiled_matmul_engine: output-stationary MxN systolic grid computing C = A*B one K-beat at a time
module tiled_matmul_engine #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int KW = 8
) (
  input logic clk,
  input logic rst,
  tiled_matmul_engine_if.slave bus
);
  localparam int L   = M + N - 1;
  localparam int IW  = M > 1 ? $clog2(M) : 1;
  localparam int DCW = $clog2(L + 1);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, OUT, FIN} state_t;
  state_t state, nxt;
  logic [KW-1:0] klen, cnt;
  logic [DCW-1:0] dcnt;
  logic [IW-1:0] r;
  logic rdy, fire;
  // Row i of ar enters at M-1-i so it reaches the grid column 0 after i cycles of skew;
  // ar[i][M-1+j] is the A operand seen by PE(i,j). br mirrors this for columns.
  logic signed [DW-1:0] ar [M][L];
  logic signed [DW-1:0] br [N][L];
  logic signed [AW-1:0] acc [M][N];
  assign rdy         = state == LOAD && cnt < klen;
  assign fire        = rdy && bus.a_valid && bus.b_valid;
  assign bus.a_ready = rdy;
  assign bus.b_ready = rdy;
  assign bus.c_valid = state == OUT;
  assign bus.c_idx   = state == OUT ? r : '0;
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == FIN;
  always_comb begin
    bus.c_row = '0;
    for (int j = 0; j < N; j++) bus.c_row[j*AW +: AW] = state == OUT ? acc[r][j] : '0;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? (bus.k_len != '0 ? LOAD : DRAIN) : IDLE;
      LOAD:    nxt = (fire && cnt == klen - KW'(1)) ? DRAIN : LOAD;
      DRAIN:   nxt = dcnt == DCW'(L - 1) ? OUT : DRAIN;
      OUT:     nxt = (bus.c_ready && r == IW'(M - 1)) ? FIN : OUT;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      klen  <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      r     <= '0;
      ar    <= '{default: '0};
      br    <= '{default: '0};
      acc   <= '{default: '0};
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        klen <= bus.k_len;
        cnt  <= '0;
        dcnt <= '0;
        r    <= '0;
        ar   <= '{default: '0};
        br   <= '{default: '0};
        acc  <= '{default: '0};
      end else begin
        if (fire) cnt <= cnt + KW'(1);
        if (state == DRAIN) dcnt <= dcnt + DCW'(1);
        if (state == OUT && bus.c_ready) r <= r + IW'(1);
        if (state == LOAD || state == DRAIN) begin
          for (int i = 0; i < M; i++) begin
            for (int p = 1; p < L; p++) if (p > M - 1 - i) ar[i][p] <= ar[i][p-1];
            ar[i][M-1-i] <= fire ? bus.a_col[i*DW +: DW] : '0;
          end
          for (int j = 0; j < N; j++) begin
            for (int p = 1; p < L; p++) if (p > N - 1 - j) br[j][p] <= br[j][p-1];
            br[j][N-1-j] <= fire ? bus.b_row[j*DW +: DW] : '0;
          end
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              acc[i][j] <= acc[i][j] + AW'(ar[i][M-1+j]) * AW'(br[j][N-1+i]);
        end
      end
    end
  end
endmodule

// File: tb/tb_tiled_matmul_engine.sv
// tb_tiled_matmul_engine: randomized jobs checked against a plain matrix-product model of the engine
module tb_tiled_matmul_engine;
  localparam int M = 4, N = 4, DW = 16, AW = 32, KW = 8, KMAX = 16;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  tiled_matmul_engine_if #(.M(M), .N(N), .DW(DW), .AW(AW), .KW(KW)) bus();
  tiled_matmul_engine #(.M(M), .N(N), .DW(DW), .AW(AW), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0, mismatched = 0, cyc = 0, exp_row = 0;
  shortint ga [M][KMAX];
  shortint gb [KMAX][N];
  logic signed [AW-1:0] ec [M][N];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  function automatic void model(input int k);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int kk = 0; kk < k; kk++) s += int'(ga[i][kk]) * int'(gb[kk][j]);
        ec[i][j] = s;
      end
  endfunction
  // Every visible result row must be the next expected row of the model, and must not move while stalled.
  initial begin
    bit prev_hold = 0;
    logic [N*AW-1:0] prev_row = '0;
    int prev_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.c_valid) begin
        if (prev_hold) begin
          chk("hold_row", 32'(bus.c_row != prev_row), 0);
          chk("hold_idx", 32'(bus.c_idx), prev_idx);
        end
        chk("row_in_range", 32'(exp_row < M), 1);
        if (exp_row < M) begin
          chk("c_idx", 32'(bus.c_idx), exp_row);
          for (int j = 0; j < N; j++) chk($sformatf("c[%0d][%0d]", exp_row, j), bus.c_row[j*AW +: AW], ec[exp_row][j]);
        end
        if (bus.c_ready) exp_row++;
      end
      prev_hold = !rst && bus.c_valid && !bus.c_ready;
      prev_row  = bus.c_row;
      prev_idx  = int'(bus.c_idx);
    end
  end
  task automatic chk_quiet(input string tag);
    chk({tag, "_a_ready"}, 32'(bus.a_ready), 0);
    chk({tag, "_b_ready"}, 32'(bus.b_ready), 0);
    chk({tag, "_c_valid"}, 32'(bus.c_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_c_row"}, 32'(|bus.c_row), 0);
    chk({tag, "_c_idx"}, 32'(bus.c_idx), 0);
  endtask
  // Called just after a rising edge; start is raised in that same cycle.
  task automatic run_job(input int k, input bit randv, input bit bp, input bit poke, input int abort_at);
    int beat = 0, guard = 0, t_last, first_cv = -1, t_done = -1, rows = 0, hold = 0, dones = 0;
    bit seen_ready = 0, av, bv;
    model(k);
    exp_row = 0;
    bus.start = 1;
    bus.k_len = k[KW-1:0];
    @(negedge clk);
    t_last = cyc;
    seen_ready |= bus.a_ready | bus.b_ready;
    @(posedge clk); #1;
    bus.start = 0;
    while (beat < k && guard < 400) begin
      av = randv ? 1'($urandom % 2) : 1'b1;
      bv = randv ? 1'($urandom % 2) : 1'b1;
      bus.a_valid = av;
      bus.b_valid = bv;
      for (int i = 0; i < M; i++) bus.a_col[i*DW +: DW] = (av && bv) ? ga[i][beat] : DW'($urandom);
      for (int j = 0; j < N; j++) bus.b_row[j*DW +: DW] = (av && bv) ? gb[beat][j] : DW'($urandom);
      bus.start = poke ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
      seen_ready |= bus.a_ready | bus.b_ready;
      if (bus.a_ready && av && bv) begin
        beat++;
        t_last = cyc;
      end
      @(posedge clk); #1;
      guard++;
      if (abort_at != 0 && beat == abort_at) return;
    end
    chk("beats_accepted", beat, k);
    bus.a_valid = 0;
    bus.b_valid = 0;
    guard = 0;
    while (t_done < 0 && guard < 200) begin
      bus.c_ready = !(bp && rows == 1 && hold < 3);
      bus.start = poke ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
      seen_ready |= bus.a_ready | bus.b_ready;
      if (bus.c_valid && first_cv < 0) first_cv = cyc;
      if (bus.c_valid && !bus.c_ready) hold++;
      if (bus.c_valid && bus.c_ready) rows++;
      if (bus.done) begin
        t_done = cyc;
        dones++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.start = 0;
    bus.c_ready = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("first_c_valid_cycle", first_cv, t_last + M + N);
    chk("done_cycle", t_done, t_last + 2*M + N + (bp ? 3 : 0));
    chk("rows_accepted", rows, M);
    chk("done_pulses", dones, 1);
    chk("idle_after_job", 32'(bus.busy), 0);
    if (k == 0) chk("no_ready_k0", 32'(seen_ready), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 0; bus.k_len = '0; bus.a_valid = 0; bus.b_valid = 0;
    bus.a_col = '0; bus.b_row = '0; bus.c_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 0;
    // Identity A times counting B returns B.
    for (int i = 0; i < M; i++) for (int k = 0; k < 4; k++) ga[i][k] = shortint'(i == k);
    for (int k = 0; k < 4; k++) for (int j = 0; j < N; j++) gb[k][j] = shortint'(4*k + j + 1);
    model(4);
    chk("pin_ident_00", ec[0][0], 1);
    chk("pin_ident_21", ec[2][1], 10);
    chk("pin_ident_33", ec[3][3], 16);
    run_job(4, 0, 0, 0, 0);
    for (int i = 0; i < M; i++) for (int k = 0; k < 2; k++) ga[i][k] = -1;
    for (int k = 0; k < 2; k++) for (int j = 0; j < N; j++) gb[k][j] = 32767;
    model(2);
    chk("pin_signed", ec[1][2], 32'hFFFF0002);
    run_job(2, 0, 0, 0, 0);
    for (int i = 0; i < M; i++) for (int k = 0; k < 3; k++) ga[i][k] = -32768;
    for (int k = 0; k < 3; k++) for (int j = 0; j < N; j++) gb[k][j] = -32768;
    model(3);
    chk("pin_wrap", ec[3][0], 32'hC0000000);
    run_job(3, 0, 0, 0, 0);
    for (int i = 0; i < M; i++) for (int k = 0; k < 4; k++) ga[i][k] = shortint'($urandom);
    for (int k = 0; k < 4; k++) for (int j = 0; j < N; j++) gb[k][j] = shortint'($urandom);
    run_job(4, 1, 1, 1, 0);
    model(0);
    chk("pin_k0", ec[2][2], 0);
    run_job(0, 0, 0, 1, 0);
    // Abort mid-LOAD, then a fresh job starting on the very first cycle out of reset.
    run_job(4, 0, 0, 0, 2);
    bus.a_valid = 0;
    bus.b_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("abort");
    @(posedge clk); #1;
    rst = 0;
    ga[0][0] = 2; ga[1][0] = 2; ga[2][0] = 2; ga[3][0] = 2;
    for (int j = 0; j < N; j++) gb[0][j] = 3;
    model(1);
    chk("pin_after_abort", ec[1][3], 6);
    run_job(1, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      int k = int'($urandom_range(1, 6));
      for (int i = 0; i < M; i++) for (int kk = 0; kk < k; kk++) ga[i][kk] = shortint'($urandom);
      for (int kk = 0; kk < k; kk++) for (int j = 0; j < N; j++) gb[kk][j] = shortint'($urandom);
      run_job(k, 1, 1'($urandom % 2), 1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
